// File: rtl/pll_lock_sequencer.sv
// Display PLL power-up/recovery sequencer: reset pulse, lock wait with timeout/retries, stability qualify, release.
// Outputs registered from next state; optional loss-of-lock counter under LOL_COUNTER_EN.
module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int CNT_W         = 20
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [2:0] state,
   output logic [3:0] retries
`ifdef LOL_COUNTER_EN
   ,
   output logic [7:0] lol_count
`endif
);

   typedef enum logic [2:0] {
      S_PRST  = 3'd0,
      S_WAIT  = 3'd1,
      S_STAB  = 3'd2,
      S_RUN   = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] C_RST_TC  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_LOCK_TC = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_STAB_TC = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       C_MAX_RET = 4'(MAX_RETRIES);

   logic             r_sync1;
   logic             r_sync2;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_retries;
   logic             r_pll_rst;
   logic             r_sys_rst;
   logic             r_ready;
   logic             r_fault;

   state_t           w_nxt_state;
   logic [CNT_W-1:0] w_nxt_cnt;
   logic [3:0]       w_nxt_retries;
   logic             w_lock_s;

   assign w_lock_s = r_sync2;

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_cnt     = r_cnt;
      w_nxt_retries = r_retries;
      if (restart) begin
         w_nxt_state   = S_PRST;
         w_nxt_cnt     = '0;
         w_nxt_retries = 4'd0;
      end else begin
         case (r_state)
            S_PRST: begin
               if (r_cnt == C_RST_TC) begin
                  w_nxt_state = S_WAIT;
                  w_nxt_cnt   = '0;
               end else begin
                  w_nxt_cnt = r_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (w_lock_s) begin
                  w_nxt_state = S_STAB;
                  w_nxt_cnt   = '0;
               end else if (r_cnt == C_LOCK_TC) begin
                  w_nxt_cnt = '0;
                  if (r_retries == C_MAX_RET) begin
                     w_nxt_state = S_FAULT;
                  end else begin
                     w_nxt_state   = S_PRST;
                     w_nxt_retries = r_retries + 4'd1;
                  end
               end else begin
                  w_nxt_cnt = r_cnt + 1'b1;
               end
            end
            S_STAB: begin
               // A lock glitch restarts the wait window without costing a retry.
               if (!w_lock_s) begin
                  w_nxt_state = S_WAIT;
                  w_nxt_cnt   = '0;
               end else if (r_cnt == C_STAB_TC) begin
                  w_nxt_state   = S_RUN;
                  w_nxt_cnt     = '0;
                  w_nxt_retries = 4'd0;
               end else begin
                  w_nxt_cnt = r_cnt + 1'b1;
               end
            end
            S_RUN: begin
               w_nxt_cnt = '0;
               if (!w_lock_s) begin
                  w_nxt_state = S_PRST;
               end
            end
            S_FAULT: begin
               w_nxt_state = S_FAULT;
            end
            default: begin
               w_nxt_state = S_PRST;
               w_nxt_cnt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state   <= S_PRST;
         r_cnt     <= '0;
         r_retries <= 4'd0;
         r_pll_rst <= 1'b1;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_cnt     <= w_nxt_cnt;
         r_retries <= w_nxt_retries;
         r_pll_rst <= (w_nxt_state == S_PRST) || (w_nxt_state == S_FAULT);
         r_sys_rst <= (w_nxt_state != S_RUN);
         r_ready   <= (w_nxt_state == S_RUN);
         r_fault   <= (w_nxt_state == S_FAULT);
      end
   end

   assign state   = r_state;
   assign retries = r_retries;
   assign pll_rst = r_pll_rst;
   assign sys_rst = r_sys_rst;
   assign ready   = r_ready;
   assign fault   = r_fault;

`ifdef LOL_COUNTER_EN
   logic [7:0] r_lol_cnt;
   logic       w_lol_evt;

   // Restart outranks loss of lock, so a simultaneous restart is not counted.
   assign w_lol_evt = (r_state == S_RUN) && !restart && !w_lock_s;

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_lol_cnt <= 8'd0;
      end else if (w_lol_evt && (r_lol_cnt != 8'hFF)) begin
         r_lol_cnt <= r_lol_cnt + 8'd1;
      end
   end

   assign lol_count = r_lol_cnt;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed test-plan scenarios followed by randomized lock/restart/reset traffic, all checked every cycle against a reference model.
module tb_pll_lock_sequencer;
   localparam int RC = 4;
   localparam int LT = 20;
   localparam int SC = 8;
   localparam int MR = 2;

   localparam int P_PRST  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_STAB  = 2;
   localparam int P_RUN   = 3;
   localparam int P_FAULT = 4;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       restart = 1'b0;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic [2:0] state;
   logic [3:0] retries;
`ifdef LOL_COUNTER_EN
   logic [7:0] lol_count;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   int m_phase = P_PRST;
   int m_cnt = 0;
   int m_ret = 0;
   int m_lol = 0;
   bit m_s1 = 1'b0;
   bit m_s2 = 1'b0;

   always #5 refclk = ~refclk;

   pll_lock_sequencer #(
      .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR), .CNT_W(20)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
      .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
      .state(state), .retries(retries)
`ifdef LOL_COUNTER_EN
      , .lol_count(lol_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: a lock-age pipeline plus a phase/elapsed-time view of the sequence rules.
   task automatic model_edge();
      bit ls;
      if (rst) begin
         m_phase = P_PRST; m_cnt = 0; m_ret = 0; m_lol = 0; m_s1 = 0; m_s2 = 0;
      end else begin
         ls = m_s2;
         m_s2 = m_s1;
         m_s1 = pll_locked;
         if (restart) begin
            m_phase = P_PRST; m_cnt = 0; m_ret = 0;
         end else if (m_phase == P_PRST) begin
            m_cnt++;
            if (m_cnt == RC) begin m_phase = P_WAIT; m_cnt = 0; end
         end else if (m_phase == P_WAIT) begin
            m_cnt++;
            if (ls) begin
               m_phase = P_STAB; m_cnt = 0;
            end else if (m_cnt == LT) begin
               m_cnt = 0;
               if (m_ret == MR) m_phase = P_FAULT;
               else begin m_ret++; m_phase = P_PRST; end
            end
         end else if (m_phase == P_STAB) begin
            m_cnt++;
            if (!ls) begin
               m_phase = P_WAIT; m_cnt = 0;
            end else if (m_cnt == SC) begin
               m_phase = P_RUN; m_cnt = 0; m_ret = 0;
            end
         end else if (m_phase == P_RUN) begin
            if (!ls) begin
               m_phase = P_PRST;
               if (m_lol < 255) m_lol++;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge refclk);
      model_edge();
      #1;
      chk("state", state, m_phase);
      chk("pll_rst", pll_rst, (m_phase == P_PRST) || (m_phase == P_FAULT));
      chk("sys_rst", sys_rst, m_phase != P_RUN);
      chk("ready", ready, m_phase == P_RUN);
      chk("fault", fault, m_phase == P_FAULT);
      chk("retries", retries, m_ret);
`ifdef LOL_COUNTER_EN
      chk("lol_count", lol_count, m_lol);
`endif
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      restart = 1'b0;
      run(2);
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, state, 0);
      chk({tag, "_pll_rst"}, pll_rst, 1);
      chk({tag, "_sys_rst"}, sys_rst, 1);
      chk({tag, "_ready"}, ready, 0);
      chk({tag, "_fault"}, fault, 0);
      chk({tag, "_retries"}, retries, 0);
   endtask

   initial begin
      int hold;
      // A: lock present from power-up
      pll_locked = 1'b1;
      do_reset();
      chk_reset_vals("A_rst");
      run(3);  chk("A_prst", pll_rst, 1);
      run(1);  chk("A_wait", state, P_WAIT); chk("A_prst_off", pll_rst, 0);
      run(1);  chk("A_stab", state, P_STAB);
      run(7);  chk("A_not_ready", ready, 0);
      run(1);  chk("A_ready", ready, 1); chk("A_sys_rst", sys_rst, 0); chk("A_retries", retries, 0);

      // B: lock never arrives
      pll_locked = 1'b0;
      do_reset();
      run(4);  chk("B_wait0", state, P_WAIT);
      run(20); chk("B_prst1", state, P_PRST); chk("B_ret1", retries, 1);
      run(24); chk("B_prst2", state, P_PRST); chk("B_ret2", retries, 2);
      run(23); chk("B_wait2", state, P_WAIT); chk("B_nofault", fault, 0);
      run(1);  chk("B_fault", fault, 1); chk("B_f_pll_rst", pll_rst, 1);
      chk("B_f_sys_rst", sys_rst, 1); chk("B_f_state", state, P_FAULT);
      run(100); chk("B_sticky", fault, 1); chk("B_sticky_ret", retries, 2);

      // C: restart out of fault
      pll_locked = 1'b1;
      run(3);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("C_fault_clr", fault, 0); chk("C_pll_rst", pll_rst, 1); chk("C_retries", retries, 0);
      run(12); chk("C_not_ready", ready, 0);
      run(1);  chk("C_ready", ready, 1);

      // D: 3-cycle lock glitch during stabilisation
      do_reset();
      run(7);
      pll_locked = 1'b0;
      run(3);
      pll_locked = 1'b1;
      chk("D_back_wait", state, P_WAIT); chk("D_no_retry", retries, 0);
      run(10); chk("D_not_ready", ready, 0);
      run(1);  chk("D_ready", ready, 1); chk("D_retries", retries, 0);

      // E: loss of lock while running
      pll_locked = 1'b0;
      run(2);  chk("E_still_ready", ready, 1);
      run(1);  chk("E_ready_drop", ready, 0); chk("E_sys_rst", sys_rst, 1); chk("E_pll_rst", pll_rst, 1);
      pll_locked = 1'b1;
      run(3);  chk("E_pll_rst_hold", pll_rst, 1);
      run(1);  chk("E_pll_rst_end", pll_rst, 0);
      run(9);  chk("E_relock", ready, 1);
`ifdef LOL_COUNTER_EN
      chk("E_lol", lol_count, 1);
`endif

      // F: rst and restart together mid-wait
      pll_locked = 1'b0;
      do_reset();
      run(6);  chk("F_in_wait", state, P_WAIT);
      rst = 1'b1;
      restart = 1'b1;
      step();
      chk_reset_vals("F_rst");
      rst = 1'b0;
      restart = 1'b0;
      run(2);

      // Randomized lock behaviour with sporadic restart and reset
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            pll_locked = ($urandom_range(0, 99) < 65);
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 150) : $urandom_range(1, 30);
         end
         hold--;
         restart = ($urandom_range(0, 199) == 0);
         rst = ($urandom_range(0, 999) == 0);
         step();
      end
      rst = 1'b0;
      restart = 1'b0;
      run(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
